// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/EXEC control, program counter, IR and C/Z flags.
// Optional halt/halted handshake is compiled in when FETCH_HALT_EN is defined.
module fetch_sequencer (
    input  logic        clock,
    input  logic        reset,
    output logic        rom_req,
    output logic [11:0] rom_addr,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        ctrl_load_pc,
    input  logic        ctrl_load_flags,
    output logic [3:0]  opcode,
    output logic [3:0]  operand,
    output logic        carry,
    output logic        zero,
    output logic        phase,
`ifdef FETCH_HALT_EN
    input  logic        halt,
    output logic        halted,
`endif
    output logic [11:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_halt;
    logic [11:0] r_pc;
    logic [15:0] r_ir;
    logic        r_carry;
    logic        r_zero;
    logic        r_phase;
    logic        r_romReq;

`ifdef FETCH_HALT_EN
    logic        r_halted;
    assign w_halt = halt;
    assign halted = r_halted;
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Halt is only honoured at instruction boundaries, so a started fetch always runs to EXEC.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = w_halt ? IDLE : FETCH;
            FETCH:   w_nextState = rom_ack ? EXEC : FETCH;
            EXEC:    w_nextState = w_halt ? IDLE : FETCH;
            default: w_nextState = IDLE;
        endcase
    end

    // rom_req and phase are registered from the next state so every decoder-facing output is a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc     <= 12'h000;
            r_ir     <= 16'h0000;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_phase  <= 1'b0;
            r_romReq <= 1'b0;
        end else begin
            r_phase  <= (w_nextState == EXEC);
            r_romReq <= (w_nextState == FETCH);
            if (r_state == FETCH && rom_ack) begin
                r_ir <= rom_data;
                r_pc <= r_pc + 12'd1;
            end
            if (r_state == EXEC) begin
                if (ctrl_load_pc) begin
                    r_pc <= r_ir[11:0];
                end
                if (ctrl_load_flags) begin
                    r_carry <= alu_carry;
                    r_zero  <= alu_zero;
                end
            end
        end
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_nextState == IDLE);
        end
    end
`endif

    assign rom_req  = r_romReq;
    assign rom_addr = r_pc;
    assign pc       = r_pc;
    assign opcode   = r_ir[15:12];
    assign operand  = r_ir[3:0];
    assign carry    = r_carry;
    assign zero     = r_zero;
    assign phase    = r_phase;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: driver queues expected fetch/exec observations,
// a monitor pops and compares them whenever the DUT enters FETCH or EXEC.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        rom_req;
    logic [11:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic        alu_carry;
    logic        alu_zero;
    logic        ctrl_load_pc;
    logic        ctrl_load_flags;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic        carry;
    logic        zero;
    logic        phase;
    logic [11:0] pc;
`ifdef FETCH_HALT_EN
    logic        halt;
    logic        halted;
`endif

    typedef struct packed {
        logic [11:0] addr;
        logic        c;
        logic        z;
    } fetchExp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  opr;
        logic [11:0] pcv;
    } execExp_t;

    fetchExp_t fetchQ[$];
    execExp_t  execQ[$];

    int checks = 0;
    int errors = 0;

    logic [11:0] mPc;
    logic        mC;
    logic        mZ;

    fetch_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .rom_req        (rom_req),
        .rom_addr       (rom_addr),
        .rom_ack        (rom_ack),
        .rom_data       (rom_data),
        .alu_carry      (alu_carry),
        .alu_zero       (alu_zero),
        .ctrl_load_pc   (ctrl_load_pc),
        .ctrl_load_flags(ctrl_load_flags),
        .opcode         (opcode),
        .operand        (operand),
        .carry          (carry),
        .zero           (zero),
        .phase          (phase),
`ifdef FETCH_HALT_EN
        .halt           (halt),
        .halted         (halted),
`endif
        .pc             (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: EXEC cycles pop execQ, the first cycle of each FETCH pops fetchQ.
    initial begin
        logic prevReq;
        execExp_t  e;
        fetchExp_t f;
        prevReq = 1'b0;
        forever begin
            @(negedge clock);
            if (phase === 1'b1) begin
                if (execQ.size() == 0) begin
                    checkOutput("execUnexpected", 16'd1, 16'd0);
                end else begin
                    e = execQ.pop_front();
                    checkOutput("execOpcode", {12'd0, opcode}, {12'd0, e.op});
                    checkOutput("execOperand", {12'd0, operand}, {12'd0, e.opr});
                    checkOutput("execPc", {4'd0, pc}, {4'd0, e.pcv});
                    checkOutput("execRomReq", {15'd0, rom_req}, 16'd0);
                end
            end
            if (rom_req === 1'b1 && prevReq !== 1'b1) begin
                if (fetchQ.size() == 0) begin
                    checkOutput("fetchUnexpected", 16'd1, 16'd0);
                end else begin
                    f = fetchQ.pop_front();
                    checkOutput("fetchAddr", {4'd0, rom_addr}, {4'd0, f.addr});
                    checkOutput("fetchPc", {4'd0, pc}, {4'd0, f.addr});
                    checkOutput("fetchCarry", {15'd0, carry}, {15'd0, f.c});
                    checkOutput("fetchZero", {15'd0, zero}, {15'd0, f.z});
                    checkOutput("fetchPhase", {15'd0, phase}, 16'd0);
                end
            end
            prevReq = rom_req;
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "RomReq"}, {15'd0, rom_req}, 16'd0);
        checkOutput({tag, "RomAddr"}, {4'd0, rom_addr}, 16'h0000);
        checkOutput({tag, "Pc"}, {4'd0, pc}, 16'h0000);
        checkOutput({tag, "Opcode"}, {12'd0, opcode}, 16'h0000);
        checkOutput({tag, "Operand"}, {12'd0, operand}, 16'h0000);
        checkOutput({tag, "Carry"}, {15'd0, carry}, 16'd0);
        checkOutput({tag, "Zero"}, {15'd0, zero}, 16'd0);
        checkOutput({tag, "Phase"}, {15'd0, phase}, 16'd0);
    endtask

    // One instruction: optional wait states, control noise during FETCH, real controls in EXEC.
    task automatic applyStimulus(input logic [15:0] data, input int waits,
                                 input logic lpc, input logic lflags,
                                 input logic ac, input logic az);
        int guard;
        guard = 0;
        @(negedge clock);
        while (rom_req !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            checkOutput("fetchTimeout", {15'd0, rom_req}, 16'd1);
            return;
        end
        ctrl_load_pc    = 1'b1;
        ctrl_load_flags = 1'b1;
        alu_carry       = ~mC;
        alu_zero        = ~mZ;
        rom_ack         = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clock);
            checkOutput("waitRomReq", {15'd0, rom_req}, 16'd1);
            checkOutput("waitAddr", {4'd0, rom_addr}, {4'd0, mPc});
            checkOutput("waitPhase", {15'd0, phase}, 16'd0);
        end
        mPc = mPc + 12'd1;
        execQ.push_back('{op: data[15:12], opr: data[3:0], pcv: mPc});
        rom_ack  = 1'b1;
        rom_data = data;
        @(posedge clock);
        #1;
        rom_ack         = 1'b1;
        rom_data        = 16'hFFFF;
        ctrl_load_pc    = lpc;
        ctrl_load_flags = lflags;
        alu_carry       = ac;
        alu_zero        = az;
        if (lpc) mPc = data[11:0];
        if (lflags) begin
            mC = ac;
            mZ = az;
        end
        fetchQ.push_back('{addr: mPc, c: mC, z: mZ});
        @(posedge clock);
        #1;
        rom_ack         = 1'b0;
        ctrl_load_pc    = 1'b0;
        ctrl_load_flags = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        rom_ack         = 1'b0;
        rom_data        = 16'h0000;
        alu_carry       = 1'b0;
        alu_zero        = 1'b0;
        ctrl_load_pc    = 1'b0;
        ctrl_load_flags = 1'b0;
`ifdef FETCH_HALT_EN
        halt            = 1'b0;
`endif
        mPc = 12'h000;
        mC  = 1'b0;
        mZ  = 1'b0;
        repeat (3) @(negedge clock);
        checkReset("reset");
        fetchQ.push_back('{addr: 12'h000, c: 1'b0, z: 1'b0});
        reset = 1'b1;

        applyStimulus(16'h4A05, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h1234, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'hC123, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h2000, 1, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'hCFFF, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h7008, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h9AB6, 0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Abort a stalled fetch with reset; nothing of the pending instruction may survive.
        @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkReset("midFetch");
        mPc = 12'h000;
        mC  = 1'b0;
        mZ  = 1'b0;
        fetchQ.push_back('{addr: 12'h000, c: 1'b0, z: 1'b0});
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("postResetReq", {15'd0, rom_req}, 16'd1);
        checkOutput("postResetAddr", {4'd0, rom_addr}, 16'h0000);

        applyStimulus(16'h5A5A, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        #1;
        checkOutput("execQEmpty", 16'(execQ.size()), 16'd0);
        checkOutput("fetchQEmpty", 16'(fetchQ.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have these ports, one clock domain; reset is asynchronous and active-low:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- rom_req  out  1  program ROM read request
- rom_addr  out  12  ROM word address, equal to the PC
- rom_ack  in  1  ROM data valid; sampled only while rom_req=1
- rom_data  in  16  instruction word: [15:12] opcode, [11:0] operand/jump address
- alu_carry  in  1  carry result from the ALU
- alu_zero  in  1  zero result from the ALU
- ctrl_load_pc  in  1  decoder control: load jump target
- ctrl_load_flags  in  1  decoder control: latch ALU flags
- opcode  out  4  IR[15:12], to decoder
- operand  out  4  IR[3:0], immediate nibble to datapath
- carry  out  1  registered C flag, to decoder
- zero  out  1  registered Z flag, to decoder
- phase  out  1  0=fetch, 1=execute, to decoder
- pc  out  12  current program counter (debug)

Function
REQ-002 The FSM SHALL have states IDLE, FETCH and EXEC, binary-encoded and registered.
REQ-003 IDLE: rom_req=0, phase=0; next state is FETCH unconditionally, unless the halt feature is active (REQ-015).
REQ-004 FETCH: rom_req=1, rom_addr=pc, phase=0; the FSM stays in FETCH for any number of cycles while rom_ack=0 (wait states).
REQ-005 In FETCH with rom_ack=1, the block SHALL, on that edge, load IR<=rom_data, set pc<=pc+1 modulo 4096 (0xFFF wraps to 0x000), and move to EXEC.
REQ-006 EXEC SHALL last exactly one cycle: rom_req=0, phase=1.
REQ-007 In EXEC, if ctrl_load_pc=1 then pc<=IR[11:0]; otherwise pc holds its value.
REQ-008 In EXEC, if ctrl_load_flags=1 then carry<=alu_carry and zero<=alu_zero; otherwise the flags hold.
REQ-009 From EXEC the next state SHALL be FETCH (or IDLE per REQ-015).
REQ-010 The block SHALL ignore ctrl_load_pc and ctrl_load_flags outside EXEC, and SHALL ignore rom_ack outside FETCH.
REQ-011 Minimum instruction time SHALL be 2 cycles (FETCH with same-cycle ack, then EXEC); each ROM wait cycle adds one.
REQ-012 opcode, operand, carry, zero, phase and pc SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-013 While reset=0, the block SHALL force state=IDLE, pc=0x000, IR=0x0000, carry=0, zero=0, phase=0, rom_req=0; rom_addr therefore reads 0x000.
REQ-014 Reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction with no pc or flag update; the first fetch after release SHALL be at address 0x000, one cycle after the first rising edge.

Configuration
REQ-015 With macro FETCH_HALT_EN defined, the block SHALL add input halt (1 bit) and output halted (1 bit, reset 0). When halt=1 at an IDLE or EXEC edge, the next state is IDLE, the block holds IDLE with halted=1, and an in-progress FETCH/EXEC completes first. Deasserting halt resumes FETCH at the held pc on the next edge.
REQ-016 Without FETCH_HALT_EN, neither the halt nor the halted port exists and IDLE is transient, used only after reset.

Verification
REQ-017 Release reset, ROM acks immediately with 0x4A05 -> rom_req cycle with rom_addr=0x000; next cycle opcode=0x4, operand=0x5, phase=1, pc=0x001.
REQ-018 Hold rom_ack=0 for 3 cycles in FETCH -> rom_req stays 1, rom_addr stable, phase=0, pc unchanged; ack on the 4th cycle -> EXEC follows.
REQ-019 Fetch 0xC123, assert ctrl_load_pc in EXEC -> next FETCH has rom_addr=0x123; with ctrl_load_pc=0 -> rom_addr=pc+1.
REQ-020 pc=0xFFF, fetch acked -> pc=0x000 in EXEC.
REQ-021 Set ctrl_load_flags=1 with alu_carry=1, alu_zero=0 in EXEC -> carry=1, zero=0; pulse ctrl_load_flags during FETCH -> flags unchanged.
REQ-022 Assert reset during a FETCH wait -> all outputs reach reset values immediately; the first post-reset rom_addr is 0x000. With FETCH_HALT_EN: assert halt mid-FETCH -> EXEC completes, then halted=1 and rom_req=0.
